// File: rtl/mat_interleave_sched.sv
// mat_interleave_sched: merges A and B element streams into alternating bursts, A first
// Ports: i_clk, i_rst_n (async, active-low), i_clk_e (clock enable), i_start (frame start, IDLE only);
//   s_axis_a_* / s_axis_b_* source streams; m_axis_* merged stream (user = source, last = final beat);
//   o_busy while sending, o_done one-cycle pulse at frame end.
module mat_interleave_sched #(
  parameter int DATA_W      = 16,
  parameter int BURST       = 3,
  parameter int FRAME_BEATS = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_e,
  input  logic              i_start,
  input  logic              s_axis_a_valid,
  output logic              s_axis_a_ready,
  input  logic [DATA_W-1:0] s_axis_a_data,
  input  logic              s_axis_b_valid,
  output logic              s_axis_b_ready,
  input  logic [DATA_W-1:0] s_axis_b_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic [DATA_W-1:0] m_axis_data,
  output logic              m_axis_user,
  output logic              m_axis_last,
  output logic              o_busy,
  output logic              o_done
);
  localparam int CW = $clog2(FRAME_BEATS + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [CW-1:0] F_LAST = CW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] F_ALL = CW'(FRAME_BEATS);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);
  localparam logic [CW:0] BEAT_LAST = (CW + 1)'(2 * FRAME_BEATS - 1);
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic sel_a, sel_b, hs, own_last, other_left, grant_end;
  assign sel_a = state_q == SEND_A;
  assign sel_b = state_q == SEND_B;
  assign hs = m_axis_valid & m_axis_ready;
  // "own" is the source currently granted, "other" the one waiting
  assign own_last = sel_b ? b_cnt_q == F_LAST : a_cnt_q == F_LAST;
  assign other_left = sel_b ? a_cnt_q != F_ALL : b_cnt_q != F_ALL;
  assign grant_end = burst_cnt_q == B_LAST || own_last;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
  // hs is already gated by i_clk_e, so the send states need no extra enable term
  always_comb begin
    state_d     = state_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: if (i_start && i_clk_e) begin
        state_d     = SEND_A;
        a_cnt_d     = '0;
        b_cnt_d     = '0;
        burst_cnt_d = '0;
      end
      SEND_A, SEND_B: if (hs) begin
        a_cnt_d     = a_cnt_q + CW'(sel_a);
        b_cnt_d     = b_cnt_q + CW'(sel_b);
        burst_cnt_d = grant_end ? '0 : burst_cnt_q + BW'(1);
        if (grant_end)
          state_d = other_left ? (sel_a ? SEND_B : SEND_A) : own_last ? DONE : state_q;
      end
      default: if (i_clk_e) state_d = IDLE;
    endcase
  end
  always_comb begin
    m_axis_valid   = i_clk_e & (sel_a & s_axis_a_valid | sel_b & s_axis_b_valid);
    s_axis_a_ready = i_clk_e & sel_a & m_axis_ready;
    s_axis_b_ready = i_clk_e & sel_b & m_axis_ready;
    m_axis_data    = sel_a ? s_axis_a_data : sel_b ? s_axis_b_data : '0;
    m_axis_user    = sel_b;
    m_axis_last    = m_axis_valid & (({1'b0, a_cnt_q} + {1'b0, b_cnt_q}) == BEAT_LAST);
    o_busy         = sel_a | sel_b;
    o_done         = i_clk_e & (state_q == DONE);
  end
endmodule

// File: tb/tb_mat_interleave_sched.sv
// tb_mat_interleave_sched: randomized directed checks of mat_interleave_sched against a burst-order model
module tb_mat_interleave_sched;
  localparam int BURST = 3;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic av = 1'b0, bv = 1'b0, rdy = 1'b0, sel = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;
  logic ar0, br0, mv0, mu0, ml0, busy0, done0, ar1, br1, mv1, mu1, ml1, busy1, done1;
  logic [15:0] md0, md1;
  logic ar, br, mv, mu, ml, busy, done;
  logic [15:0] md;
  int total = 0, fails = 0, a_sent = 0, b_sent = 0;
  bit exp_u[$];
  int exp_i[$];

  always #5 clk = ~clk;

  mat_interleave_sched #(.DATA_W(16), .BURST(BURST), .FRAME_BEATS(9)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_e(ce), .i_start(start0),
    .s_axis_a_valid(av), .s_axis_a_ready(ar0), .s_axis_a_data(a_data),
    .s_axis_b_valid(bv), .s_axis_b_ready(br0), .s_axis_b_data(b_data),
    .m_axis_valid(mv0), .m_axis_ready(rdy), .m_axis_data(md0), .m_axis_user(mu0),
    .m_axis_last(ml0), .o_busy(busy0), .o_done(done0));

  mat_interleave_sched #(.DATA_W(16), .BURST(BURST), .FRAME_BEATS(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_e(ce), .i_start(start1),
    .s_axis_a_valid(av), .s_axis_a_ready(ar1), .s_axis_a_data(a_data),
    .s_axis_b_valid(bv), .s_axis_b_ready(br1), .s_axis_b_data(b_data),
    .m_axis_valid(mv1), .m_axis_ready(rdy), .m_axis_data(md1), .m_axis_user(mu1),
    .m_axis_last(ml1), .o_busy(busy1), .o_done(done1));

  assign ar = sel ? ar1 : ar0;
  assign br = sel ? br1 : br0;
  assign mv = sel ? mv1 : mv0;
  assign mu = sel ? mu1 : mu0;
  assign ml = sel ? ml1 : ml0;
  assign md = sel ? md1 : md0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat order: alternate bursts of up to BURST beats, A first, skipping exhausted sources
  function automatic void build(input int f);
    int al = f, bl = f, n;
    bit cur = 1'b0;
    exp_u.delete();
    exp_i.delete();
    while (al + bl > 0) begin
      n = cur ? (bl < BURST ? bl : BURST) : (al < BURST ? al : BURST);
      for (int k = 0; k < n; k++) begin
        exp_u.push_back(cur);
        exp_i.push_back(cur ? f - bl : f - al);
        if (cur) bl--; else al--;
      end
      if ((cur ? al : bl) > 0) cur = ~cur;
    end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, mv, 0);
    chk({tag, "_a_ready"}, ar, 0);
    chk({tag, "_b_ready"}, br, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_last"}, ml, 0);
    chk({tag, "_user"}, mu, 0);
    chk({tag, "_data"}, md, 0);
  endtask

  task automatic run_frame(input bit s, input int f, input bit rnd_rdy, input bit rnd_val,
                           input int gap_at, input int restart_at, input int rst_at);
    int beat = 0, gap = 0, budget = 0;
    bit u;
    logic [15:0] e;
    sel = s;
    build(f);
    a_sent = 0;
    b_sent = 0;
    @(negedge clk);
    ce = 1; rdy = 1; av = 1; bv = 1; start0 = !s; start1 = s;
    a_data = 16'hA000; b_data = 16'hB000;
    #1;
    chk("idle_valid", mv, 0);
    chk("idle_a_ready", ar, 0);
    while (beat < 2 * f && budget < 2000) begin
      @(negedge clk);
      budget++;
      ce = gap > 0 ? 1'b0 : 1'b1;
      if (gap > 0) gap--;
      rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      av = rnd_val ? ($urandom_range(0, 3) != 0) : 1'b1;
      bv = rnd_val ? ($urandom_range(0, 3) != 0) : 1'b1;
      start0 = 0; start1 = 0;
      if (beat == restart_at) begin start0 = !s; start1 = s; end
      a_data = 16'hA000 + 16'(a_sent);
      b_data = 16'hB000 + 16'(b_sent);
      #1;
      u = exp_u[beat];
      chk("m_valid", mv, ce & (u ? bv : av));
      chk("a_ready", ar, ce & rdy & !u);
      chk("b_ready", br, ce & rdy & u);
      if (ce) chk("busy", busy, 1);
      if (av & ar) a_sent++;
      if (bv & br) b_sent++;
      if (mv & rdy) begin
        e = (u ? 16'hB000 : 16'hA000) + 16'(exp_i[beat]);
        chk("data", md, e);
        chk("user", mu, u);
        chk("last", ml, beat == 2 * f - 1);
        beat++;
        if (beat == gap_at + 1) gap = 5;
        if (beat == rst_at + 1) begin
          @(posedge clk);
          #2 rst_n = 0;
          #1 chk_zero("rst");
          @(negedge clk);
          rst_n = 1;
          return;
        end
      end
    end
    chk("frame_beats", beat, 2 * f);
    @(negedge clk);
    ce = 1; rdy = 1; start0 = 0; start1 = 0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_valid", mv, 0);
    chk("done_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid2", mv, 0);
  endtask

  initial begin
    #2 chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    #1 chk_zero("post_reset");
    run_frame(0, 9, 0, 0, -1, -1, -1);
    run_frame(1, 4, 0, 0, -1, -1, -1);
    run_frame(0, 9, 1, 0, -1, -1, -1);
    run_frame(0, 9, 0, 0, 1, -1, -1);
    run_frame(0, 9, 0, 0, -1, 4, -1);
    run_frame(0, 9, 0, 0, -1, -1, 7);
    run_frame(0, 9, 0, 0, -1, -1, -1);
    run_frame(0, 9, 1, 1, -1, -1, -1);
    run_frame(1, 4, 1, 1, -1, -1, -1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
